// File: rtl/ring_pkg.sv
// Shared types and constants for the ring flasher monitor: LED width, FSM states,
// error codes and step direction codes.
package ring_pkg;
  localparam int LED_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MULTI   = 2'b01;
  localparam logic [1:0] ERR_NONADJ  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [1:0] DIR_FIRST = 2'b00;
  localparam logic [1:0] DIR_CW    = 2'b01;
  localparam logic [1:0] DIR_CCW   = 2'b10;
  localparam logic [1:0] DIR_SAME  = 2'b11;
endpackage

// File: rtl/ring_step_enc.sv
// Classifies an LED change vector as none / one-hot / multi-bit and encodes the index.
// Purely combinational, zero latency, no backpressure.
module ring_step_enc
  import ring_pkg::*;
(
  input  logic [LED_W-1:0] delta,
  output logic             one_hot,
  output logic             multi,
  output logic [3:0]       idx
);
  logic any_bit;
  logic single;

  assign any_bit = (delta != '0);
  assign single  = ((delta & (delta - 16'd1)) == '0);
  assign one_hot = any_bit && single;
  assign multi   = any_bit && !single;

  // Index is only meaningful when one_hot is set; highest set bit wins otherwise.
  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < LED_W; i++) begin
      if (delta[i]) idx = 4'(i);
    end
  end
endmodule

// File: rtl/ring_flasher_monitor.sv
// Watches a 16-LED ring, reports single-LED steps, burst completion and protocol errors; 1-cycle registered outputs, no backpressure.
// Optional RING_MON_STATS_EN adds saturating CW/CCW step counters (cw_steps, ccw_steps).
module ring_flasher_monitor
  import ring_pkg::*;
#(
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LED_W-1:0] led,
  input  logic             clr_err,
  output logic             step_valid,
  output logic [3:0]       step_idx,
  output logic             step_set,
  output logic [1:0]       step_dir,
  output logic             seq_done,
  output logic [7:0]       seq_len,
  output logic [7:0]       seq_count,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             err_flag
`ifdef RING_MON_STATS_EN
  ,
  output logic [15:0]      cw_steps,
  output logic [15:0]      ccw_steps
`endif
);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] delta;
  logic             one_hot;
  logic             multi;
  logic [3:0]       idx;

  state_t     state, state_n;
  logic [7:0] idle_cnt, idle_n;
  logic [3:0] last_idx, last_n;
  logic [7:0] burst_len, blen_n;
  logic [3:0] cw_idx, ccw_idx;

  logic       stv_n, sset_n, done_n, err_n;
  logic [3:0] sidx_n;
  logic [1:0] sdir_n, ecode_n;
  logic [7:0] slen_n, scnt_n;

  assign delta   = led ^ led_q;
  assign cw_idx  = last_idx + 4'd1;
  assign ccw_idx = last_idx - 4'd1;

  ring_step_enc u_enc (
    .delta   (delta),
    .one_hot (one_hot),
    .multi   (multi),
    .idx     (idx)
  );

  always_comb begin
    state_n = state;
    idle_n  = idle_cnt;
    last_n  = last_idx;
    blen_n  = burst_len;
    stv_n   = 1'b0;
    sidx_n  = step_idx;
    sset_n  = step_set;
    sdir_n  = step_dir;
    done_n  = 1'b0;
    slen_n  = seq_len;
    scnt_n  = seq_count;
    err_n   = 1'b0;
    ecode_n = err_code;
    case (state)
      S_IDLE: begin
        if (multi) begin
          err_n   = 1'b1;
          ecode_n = ERR_MULTI;
          state_n = S_ERROR;
        end else if (one_hot) begin
          stv_n   = 1'b1;
          sidx_n  = idx;
          sset_n  = led[idx];
          sdir_n  = DIR_FIRST;
          last_n  = idx;
          blen_n  = 8'd1;
          idle_n  = 8'd0;
          state_n = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (multi) begin
          err_n   = 1'b1;
          ecode_n = ERR_MULTI;
          state_n = S_ERROR;
        end else if (one_hot) begin
          if (idx == cw_idx || idx == ccw_idx || idx == last_idx) begin
            stv_n  = 1'b1;
            sidx_n = idx;
            sset_n = led[idx];
            sdir_n = (idx == cw_idx) ? DIR_CW : (idx == ccw_idx) ? DIR_CCW : DIR_SAME;
            last_n = idx;
            idle_n = 8'd0;
            blen_n = (burst_len == 8'hFF) ? burst_len : burst_len + 8'd1;
            if (led == '0) begin
              done_n  = 1'b1;
              slen_n  = blen_n;
              scnt_n  = seq_count + 8'd1;
              blen_n  = 8'd0;
              state_n = S_IDLE;
            end
          end else begin
            err_n   = 1'b1;
            ecode_n = ERR_NONADJ;
            state_n = S_ERROR;
          end
        end else if (idle_cnt + 8'd1 == TMO) begin
          err_n   = 1'b1;
          ecode_n = ERR_TIMEOUT;
          state_n = S_ERROR;
        end else begin
          idle_n = idle_cnt + 8'd1;
        end
      end
      S_ERROR: begin
        // Ring must be dark and stable for a full cycle before monitoring resumes.
        if (led == '0 && delta == '0) begin
          state_n = S_IDLE;
          idle_n  = 8'd0;
          blen_n  = 8'd0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q      <= '0;
      state      <= S_IDLE;
      idle_cnt   <= '0;
      last_idx   <= '0;
      burst_len  <= '0;
      step_valid <= 1'b0;
      step_idx   <= '0;
      step_set   <= 1'b0;
      step_dir   <= DIR_FIRST;
      seq_done   <= 1'b0;
      seq_len    <= '0;
      seq_count  <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      err_flag   <= 1'b0;
    end else begin
      led_q      <= led;
      state      <= state_n;
      idle_cnt   <= idle_n;
      last_idx   <= last_n;
      burst_len  <= blen_n;
      step_valid <= stv_n;
      step_idx   <= sidx_n;
      step_set   <= sset_n;
      step_dir   <= sdir_n;
      seq_done   <= done_n;
      seq_len    <= slen_n;
      seq_count  <= scnt_n;
      err        <= err_n;
      err_code   <= ecode_n;
      if (err_n)        err_flag <= 1'b1;
      else if (clr_err) err_flag <= 1'b0;
    end
  end

`ifdef RING_MON_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_steps  <= '0;
      ccw_steps <= '0;
    end else if (clr_err) begin
      cw_steps  <= '0;
      ccw_steps <= '0;
    end else if (stv_n) begin
      if (sdir_n == DIR_CW && cw_steps != 16'hFFFF)   cw_steps  <= cw_steps + 16'd1;
      if (sdir_n == DIR_CCW && ccw_steps != 16'hFFFF) ccw_steps <= ccw_steps + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ring_flasher_monitor.sv
// Directed bench for ring_flasher_monitor with hand-computed expectations.
module tb_ring_flasher_monitor;
  import ring_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] led = '0;
  logic        clr_err = 1'b0;
  logic        step_valid, step_set, seq_done, err, err_flag;
  logic [3:0]  step_idx;
  logic [1:0]  step_dir, err_code;
  logic [7:0]  seq_len, seq_count;
`ifdef RING_MON_STATS_EN
  logic [15:0] cw_steps, ccw_steps;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ring_flasher_monitor #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .led        (led),
    .clr_err    (clr_err),
    .step_valid (step_valid),
    .step_idx   (step_idx),
    .step_set   (step_set),
    .step_dir   (step_dir),
    .seq_done   (seq_done),
    .seq_len    (seq_len),
    .seq_count  (seq_count),
    .err        (err),
    .err_code   (err_code),
    .err_flag   (err_flag)
`ifdef RING_MON_STATS_EN
    ,
    .cw_steps   (cw_steps),
    .ccw_steps  (ccw_steps)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one LED value for one clock and leave time for the registered outputs to settle.
  task automatic drive(input logic [15:0] v, input logic c);
    @(negedge clk);
    led     = v;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_step(input string tag, input logic [3:0] idx, input logic set, input logic [1:0] dir);
    check({tag, ".valid"}, 32'(step_valid), 32'd1);
    check({tag, ".idx"},   32'(step_idx),   32'(idx));
    check({tag, ".set"},   32'(step_set),   32'(set));
    check({tag, ".dir"},   32'(step_dir),   32'(dir));
    check({tag, ".err"},   32'(err),        32'd0);
  endtask

  task automatic chk_err(input string tag, input logic [1:0] code);
    check({tag, ".err"},   32'(err),        32'd1);
    check({tag, ".code"},  32'(err_code),   32'(code));
    check({tag, ".flag"},  32'(err_flag),   32'd1);
    check({tag, ".valid"}, 32'(step_valid), 32'd0);
    check({tag, ".done"},  32'(seq_done),   32'd0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, ".valid"}, 32'(step_valid), 32'd0);
    check({tag, ".idx"},   32'(step_idx),   32'd0);
    check({tag, ".set"},   32'(step_set),   32'd0);
    check({tag, ".dir"},   32'(step_dir),   32'd0);
    check({tag, ".done"},  32'(seq_done),   32'd0);
    check({tag, ".len"},   32'(seq_len),    32'd0);
    check({tag, ".cnt"},   32'(seq_count),  32'd0);
    check({tag, ".err"},   32'(err),        32'd0);
    check({tag, ".code"},  32'(err_code),   32'd0);
    check({tag, ".flag"},  32'(err_flag),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill and drain: last step clears bit 0 with last index 1, i.e. CCW.
    drive(16'h0001, 1'b0); chk_step("fill0", 4'd0, 1'b1, DIR_FIRST);
    drive(16'h0003, 1'b0); chk_step("fill1", 4'd1, 1'b1, DIR_CW);
    drive(16'h0001, 1'b0); chk_step("drain1", 4'd1, 1'b0, DIR_SAME);
    check("drain1.done", 32'(seq_done), 32'd0);
    drive(16'h0000, 1'b0); chk_step("drain0", 4'd0, 1'b0, DIR_CCW);
    check("drain0.done", 32'(seq_done), 32'd1);
    check("drain0.len",  32'(seq_len),  32'd4);
    check("drain0.cnt",  32'(seq_count), 32'd1);
    drive(16'h0000, 1'b0);
    check("idle.valid", 32'(step_valid), 32'd0);
    check("idle.done",  32'(seq_done),   32'd0);
    check("hold.idx",   32'(step_idx),   32'd0);
    check("hold.dir",   32'(step_dir),   32'(DIR_CCW));

    // Wrap around position 15 <-> 0.
    drive(16'h0001, 1'b0); chk_step("wrap0", 4'd0, 1'b1, DIR_FIRST);
    drive(16'h8001, 1'b0); chk_step("wrap15", 4'd15, 1'b1, DIR_CCW);
    drive(16'h8000, 1'b0); chk_step("wrapcw", 4'd0, 1'b0, DIR_CW);
    drive(16'h0000, 1'b0); chk_step("wrapend", 4'd15, 1'b0, DIR_CCW);
    check("wrapend.done", 32'(seq_done),  32'd1);
    check("wrapend.len",  32'(seq_len),   32'd4);
    check("wrapend.cnt",  32'(seq_count), 32'd2);

    // Non-adjacent step, then recovery through a stable dark ring.
    drive(16'h0001, 1'b0); chk_step("na0", 4'd0, 1'b1, DIR_FIRST);
    drive(16'h0005, 1'b0); chk_err("nonadj", ERR_NONADJ);
    drive(16'h0000, 1'b0);
    check("nadark.err",   32'(err),        32'd0);
    check("nadark.valid", 32'(step_valid), 32'd0);
    drive(16'h0000, 1'b0);
    check("naidle.flag",  32'(err_flag),   32'd1);
    check("naidle.code",  32'(err_code),   32'(ERR_NONADJ));
    drive(16'h0000, 1'b1);
    check("clr.flag", 32'(err_flag), 32'd0);

    // Multi-bit change from IDLE, with clr_err in the same cycle (set wins).
    drive(16'h0003, 1'b1); chk_err("multi", ERR_MULTI);
    check("multi.cnt", 32'(seq_count), 32'd2);
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b0);
    drive(16'h0004, 1'b0); chk_step("postmulti", 4'd2, 1'b1, DIR_FIRST);
    drive(16'h0000, 1'b0);
    check("pm.done", 32'(seq_done), 32'd1);
    check("pm.len",  32'(seq_len),  32'd2);
    check("pm.cnt",  32'(seq_count), 32'd3);

    // Timeout on the 4th idle cycle.
    drive(16'h0001, 1'b0); chk_step("to0", 4'd0, 1'b1, DIR_FIRST);
    for (int i = 1; i <= 3; i++) begin
      drive(16'h0001, 1'b0);
      check($sformatf("to_idle%0d.err", i), 32'(err), 32'd0);
    end
    drive(16'h0001, 1'b0); chk_err("timeout", ERR_TIMEOUT);
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b0);

    // A step in the would-be timeout cycle suppresses the timeout.
    drive(16'h0001, 1'b0); chk_step("ts0", 4'd0, 1'b1, DIR_FIRST);
    repeat (3) drive(16'h0001, 1'b0);
    drive(16'h0003, 1'b0); chk_step("ts1", 4'd1, 1'b1, DIR_CW);

    // Error in what would be the seq_done cycle: no done, no count update.
    drive(16'h0000, 1'b0); chk_err("errdone", ERR_MULTI);
    check("errdone.cnt", 32'(seq_count), 32'd3);
    drive(16'h0000, 1'b0);

    // Reset mid-burst abandons it silently.
    drive(16'h0001, 1'b0); chk_step("rb0", 4'd0, 1'b1, DIR_FIRST);
    drive(16'h0003, 1'b0); chk_step("rb1", 4'd1, 1'b1, DIR_CW);
    @(negedge clk);
    rst = 1'b1;
    led = 16'h0000;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    drive(16'h0004, 1'b0); chk_step("afterrst", 4'd2, 1'b1, DIR_FIRST);
    check("afterrst.cnt", 32'(seq_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
